// File: rtl/c_handshake_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | c_handshake_ctrl_pkg : shared types/constants for stage C elements |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package c_handshake_ctrl_pkg;

  localparam int unsigned C_SYNC_STAGES_DFLT = 2;
  localparam int unsigned C_DELAY_DFLT       = 0;
  localparam int unsigned C_CNT_W            = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CAPT = 3'd1,
    ST_DLY  = 3'd2,
    ST_REQ  = 3'd3,
    ST_RTZ  = 3'd4
  } state_e;

  // A new packet may only be taken when both handshake phases are closed.
  function automatic logic capture_ok(input state_e st, input logic s_send,
                                      input logic s_ack, input logic ack_out);
    return (st == ST_IDLE) && s_send && !s_ack && !ack_out;
  endfunction

endpackage

`default_nettype wire

// File: rtl/c_handshake_ctrl_if.sv
// +--------------------------------------------------------------------+
// | c_handshake_ctrl_if : 4-phase request/acknowledge bundle of a stage |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface c_handshake_ctrl_if;

  logic Send_in;
  logic Ack_in;
  logic Send_out;
  logic Ack_out;
  logic CP;

  modport slave (
    input  Send_in,
    input  Ack_in,
    output Send_out,
    output Ack_out,
    output CP
  );

  modport master (
    output Send_in,
    output Ack_in,
    input  Send_out,
    input  Ack_out,
    input  CP
  );

endinterface

`default_nettype wire

// File: rtl/c_handshake_ctrl_sync.sv
// +--------------------------------------------------------------------+
// | c_sync : N-flop async-reset synchronizer, N=0 degenerates to a wire |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module c_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = clk ^ rst_n;
      assign q = d;
    end else begin : g_flops
      logic [STAGES-1:0] sync_q;
      logic [STAGES-1:0] sync_d;

      always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = d;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q <= sync_d;
        end
      end

      assign q = sync_q[STAGES-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/c_handshake_ctrl.sv
// +--------------------------------------------------------------------+
// | c_handshake_ctrl : per-stage 4-phase handshake sequencer with CP   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module c_handshake_ctrl
  import c_handshake_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = C_SYNC_STAGES_DFLT,
  parameter int unsigned DELAY       = C_DELAY_DFLT
) (
  input  logic              CLK,
  input  logic              MR,
  c_handshake_ctrl_if.slave hs
);

  localparam logic [C_CNT_W-1:0] C_DLY_LOAD =
    (DELAY == 0) ? '0 : C_CNT_W'(DELAY - 1);

  logic s_send;
  logic s_ack;

  c_sync #(.STAGES(SYNC_STAGES)) u_sync_send (
    .clk   (CLK),
    .rst_n (MR),
    .d     (hs.Send_in),
    .q     (s_send)
  );

  c_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk   (CLK),
    .rst_n (MR),
    .d     (hs.Ack_in),
    .q     (s_ack)
  );

  state_e             state_q,    state_d;
  logic [C_CNT_W-1:0] cnt_q,      cnt_d;
  logic               cp_q,       cp_d;
  logic               ack_out_q,  ack_out_d;
  logic               send_out_q, send_out_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cp_d       = 1'b0;
    ack_out_d  = ack_out_q;
    send_out_d = send_out_q;

    // Upstream return-to-zero closes independently of downstream progress.
    if (ack_out_q && !s_send) begin
      ack_out_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (capture_ok(state_q, s_send, s_ack, ack_out_q)) begin
          cp_d      = 1'b1;
          ack_out_d = 1'b1;
          state_d   = ST_CAPT;
        end
      end
      ST_CAPT: begin
        if (DELAY == 0) begin
          send_out_d = 1'b1;
          state_d    = ST_REQ;
        end else begin
          cnt_d   = C_DLY_LOAD;
          state_d = ST_DLY;
        end
      end
      ST_DLY: begin
        if (cnt_q == '0) begin
          send_out_d = 1'b1;
          state_d    = ST_REQ;
        end else begin
          cnt_d = cnt_q - C_CNT_W'(1);
        end
      end
      ST_REQ: begin
        if (s_ack) begin
          send_out_d = 1'b0;
          state_d    = ST_RTZ;
        end
      end
      ST_RTZ: begin
        if (!s_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cp_q       <= 1'b0;
      ack_out_q  <= 1'b0;
      send_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cp_q       <= cp_d;
      ack_out_q  <= ack_out_d;
      send_out_q <= send_out_d;
    end
  end

  assign hs.CP       = cp_q;
  assign hs.Ack_out  = ack_out_q;
  assign hs.Send_out = send_out_q;

endmodule

`default_nettype wire

// File: tb/tb_c_handshake_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_c_handshake_ctrl : directed + randomized bench for three configs |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_c_handshake_ctrl;

  localparam int S_A = 2, D_A = 0;
  localparam int S_B = 2, D_B = 3;
  localparam int S_C = 0, D_C = 2;
  localparam int N_RAND = 100;
  localparam int TMO    = 100;

  logic clk = 1'b0;
  logic mr  = 1'b0;
  always #5 clk = ~clk;

  c_handshake_ctrl_if hs_a ();
  c_handshake_ctrl_if hs_b ();
  c_handshake_ctrl_if hs_c ();

  c_handshake_ctrl #(.SYNC_STAGES(S_A), .DELAY(D_A)) u_dut_a (.CLK(clk), .MR(mr), .hs(hs_a));
  c_handshake_ctrl #(.SYNC_STAGES(S_B), .DELAY(D_B)) u_dut_b (.CLK(clk), .MR(mr), .hs(hs_b));
  c_handshake_ctrl #(.SYNC_STAGES(S_C), .DELAY(D_C)) u_dut_c (.CLK(clk), .MR(mr), .hs(hs_c));

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // w: 0=CP 1=Ack_out 2=Send_out
  function automatic logic sig(input int d, input int w);
    case (d)
      0:       return (w == 0) ? hs_a.CP : (w == 1) ? hs_a.Ack_out : hs_a.Send_out;
      1:       return (w == 0) ? hs_b.CP : (w == 1) ? hs_b.Ack_out : hs_b.Send_out;
      default: return (w == 0) ? hs_c.CP : (w == 1) ? hs_c.Ack_out : hs_c.Send_out;
    endcase
  endfunction

  // w: 0=Send_in 1=Ack_in
  task automatic set_in(input int d, input int w, input logic v);
    case (d)
      0: if (w == 0) hs_a.Send_in = v; else hs_a.Ack_in = v;
      1: if (w == 0) hs_b.Send_in = v; else hs_b.Ack_in = v;
      default: if (w == 0) hs_c.Send_in = v; else hs_c.Ack_in = v;
    endcase
  endtask

  // Edges elapsed until the output reaches val; TMO on expiry.
  task automatic wait_for(input int d, input int w, input logic v, output int n);
    n = 0;
    while (sig(d, w) !== v && n < TMO) begin
      tick();
      n++;
    end
  endtask

  // One full transfer with immediate handshakes, latencies from the timing rules.
  task automatic run_xfer(input int d, input int s, input int dl, input string tag);
    int n;
    set_in(d, 0, 1'b1);
    wait_for(d, 0, 1'b1, n);
    check_val({tag, "_cp_lat"}, n, s + 1);
    check_val({tag, "_ack_at_cp"}, sig(d, 1), 1);
    tick();
    check_val({tag, "_cp_width"}, sig(d, 0), 0);
    wait_for(d, 2, 1'b1, n);
    check_val({tag, "_sendout_rise"}, n + 1, dl + 1);
    set_in(d, 1, 1'b1);
    wait_for(d, 2, 1'b0, n);
    check_val({tag, "_sendout_fall"}, n, s + 1);
    check_val({tag, "_ack_held"}, sig(d, 1), 1);
    set_in(d, 0, 1'b0);
    wait_for(d, 1, 1'b0, n);
    check_val({tag, "_ackout_fall"}, n, s + 1);
    set_in(d, 1, 1'b0);
    repeat (s + 3) tick();
  endtask

  int cp_a = 0;
  always @(negedge clk) if (hs_a.CP === 1'b1) cp_a++;

  // Transaction-level observer for the random run on instance C.
  logic mon_c = 1'b0;
  int   cyc_c = 0, cps_c = 0, done_obs_c = 0, done_c = 0;
  int   ack_rise_cyc = 0, send_fall_cyc = 0;
  int   cp_cyc_q[$];
  logic p_cp = 1'b0, p_so = 1'b0, p_ao = 1'b0, p_si = 1'b0, p_ai = 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (mon_c) begin
      cyc_c++;
      if (hs_c.Ack_in && !p_ai)  ack_rise_cyc  = cyc_c;
      if (!hs_c.Send_in && p_si) send_fall_cyc = cyc_c;
      if (!hs_c.Ack_in && p_ai)  done_obs_c++;
      if (hs_c.CP) begin
        check_val("c_cp_back_to_back", p_cp, 0);
        check_val("c_cp_stage_empty", cps_c, done_obs_c);
        cps_c++;
        cp_cyc_q.push_back(cyc_c);
      end
      if (hs_c.Ack_out && !p_ao) check_val("c_ackout_with_cp", hs_c.CP, 1);
      if (hs_c.Send_out && !p_so) begin
        if (cp_cyc_q.size() == 0) check_val("c_sendout_no_cp", 32'hFFFF_FFFF, 0);
        else check_val("c_sendout_rise", cyc_c - cp_cyc_q.pop_front(), D_C + 1);
      end
      if (!hs_c.Send_out && p_so) check_val("c_sendout_fall", cyc_c - ack_rise_cyc + 1, S_C + 1);
      if (!hs_c.Ack_out && p_ao)  check_val("c_ackout_fall", cyc_c - send_fall_cyc + 1, S_C + 1);
    end
    p_cp = hs_c.CP;   p_so = hs_c.Send_out; p_ao = hs_c.Ack_out;
    p_si = hs_c.Send_in; p_ai = hs_c.Ack_in;
  end

  task automatic wait_c(input int w, input logic v, input string tag);
    int k = 0;
    while (sig(2, w) !== v && k < TMO) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, (k < TMO) ? 1 : 0, 1);
  endtask

  task automatic upstream_c();
    for (int i = 0; i < N_RAND; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      hs_c.Send_in = 1'b1;
      wait_c(1, 1'b1, "c_up_ack_rise");
      repeat ($urandom_range(0, 3)) @(negedge clk);
      hs_c.Send_in = 1'b0;
      wait_c(1, 1'b0, "c_up_ack_fall");
    end
  endtask

  task automatic downstream_c();
    int k;
    while (done_c < N_RAND) begin
      k = 0;
      while (hs_c.Send_out !== 1'b1 && k < TMO) begin
        @(negedge clk);
        k++;
      end
      if (k >= TMO) begin
        check_val("c_dn_sendout_tmo", done_c, N_RAND);
        break;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      hs_c.Ack_in = 1'b1;
      wait_c(2, 1'b0, "c_dn_sendout_fall");
      repeat ($urandom_range(0, 3)) @(negedge clk);
      hs_c.Ack_in = 1'b0;
      done_c++;
    end
  endtask

  initial begin
    int n;
    int base;
    hs_a.Send_in = 1'b1; hs_a.Ack_in = 1'b1;
    hs_b.Send_in = 1'b0; hs_b.Ack_in = 1'b0;
    hs_c.Send_in = 1'b0; hs_c.Ack_in = 1'b0;
    repeat (3) tick();
    check_val("rst_cp", hs_a.CP, 0);
    check_val("rst_ack_out", hs_a.Ack_out, 0);
    check_val("rst_send_out", hs_a.Send_out, 0);

    // Release with Send_in already high: first transfer starts from reset.
    mr = 1'b1;
    hs_a.Ack_in = 1'b0;
    run_xfer(0, S_A, D_A, "a_xfer");

    // Back-pressure: second request must wait for the first to drain.
    base = cp_a;
    hs_a.Send_in = 1'b1;
    wait_for(0, 1, 1'b1, n);
    hs_a.Send_in = 1'b0;
    wait_for(0, 1, 1'b0, n);
    hs_a.Send_in = 1'b1;
    repeat (20) tick();
    check_val("a_bp_single_cp", cp_a - base, 1);
    check_val("a_bp_ack_low", hs_a.Ack_out, 0);
    check_val("a_bp_send_held", hs_a.Send_out, 1);
    hs_a.Ack_in = 1'b1;
    wait_for(0, 2, 1'b0, n);
    hs_a.Ack_in = 1'b0;
    wait_for(0, 0, 1'b1, n);
    check_val("a_bp_second_cp_lat", n, S_A + 2);
    tick();
    check_val("a_bp_cp_count", cp_a - base, 2);

    // Asynchronous reset while requesting downstream.
    wait_for(0, 2, 1'b1, n);
    check_val("a_mid_pre_send", hs_a.Send_out, 1);
    check_val("a_mid_pre_ack", hs_a.Ack_out, 1);
    #2;
    mr = 1'b0;
    #1;
    check_val("a_mid_send_out", hs_a.Send_out, 0);
    check_val("a_mid_ack_out", hs_a.Ack_out, 0);
    check_val("a_mid_cp", hs_a.CP, 0);
    hs_a.Send_in = 1'b0;
    tick();
    mr = 1'b1;
    base = cp_a;
    repeat (6) tick();
    check_val("a_post_rst_no_cp", cp_a - base, 0);
    check_val("a_post_rst_send_out", hs_a.Send_out, 0);

    run_xfer(1, S_B, D_B, "b_xfer");

    mon_c = 1'b1;
    @(negedge clk);
    fork
      upstream_c();
      downstream_c();
    join
    repeat (5) tick();
    mon_c = 1'b0;
    check_val("c_cp_total", cps_c, N_RAND);
    check_val("c_done_total", done_c, N_RAND);
    check_val("c_cp_vs_done", cps_c, done_obs_c);
    check_val("c_pending_empty", cp_cyc_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
